// File: rtl/formula_n_pipe_aware_fsm.sv
// Sequencer computing res = sum of isqrt(arg[i]) through one external pipelined isqrt.
// Returns are counted, so gaps in isqrt_y_vld are tolerated.
module formula_n_pipe_aware_fsm #(
  parameter int unsigned N_ARGS    = 3,
  parameter int unsigned ARG_W     = 32,
  parameter int unsigned ISQRT_LAT = 4,
  parameter int unsigned RES_W     = ARG_W / 2 + $clog2(N_ARGS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arg_vld,
  output logic                      arg_rdy,
  input  logic [N_ARGS*ARG_W-1:0]   args,
  output logic                      res_vld,
  output logic [RES_W-1:0]          res,
  output logic                      isqrt_x_vld,
  output logic [ARG_W-1:0]          isqrt_x,
  input  logic                      isqrt_y_vld,
  input  logic [ARG_W/2-1:0]        isqrt_y
);

  localparam int unsigned IdxW = (N_ARGS > 1) ? $clog2(N_ARGS) : 1;
  localparam int unsigned CntW = $clog2(N_ARGS + 1);
  localparam int unsigned DrnW = $clog2(ISQRT_LAT + 1);

  typedef enum logic [2:0] {StDrain, StIdle, StIssue, StWait, StDone} state_e;

  state_e                   state_q, state_d;
  logic [DrnW-1:0]          drain_q, drain_d;
  logic [N_ARGS*ARG_W-1:0]  args_q, args_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [CntW-1:0]          ret_q, ret_d;
  logic [RES_W-1:0]         acc_q, acc_d;
  logic [RES_W-1:0]         res_q, res_d;
  logic                     x_vld_q, x_vld_d;
  logic [ARG_W-1:0]         x_q, x_d;
  logic                     transfer;
  logic                     ret_fire;
  logic [ARG_W-1:0]         next_arg;

  assign arg_rdy     = (state_q == StIdle) || (state_q == StDone);
  assign transfer    = arg_vld && arg_rdy;
  assign res_vld     = (state_q == StDone);
  assign res         = res_q;
  assign isqrt_x_vld = x_vld_q;
  assign isqrt_x     = x_q;

  // Returns outside ISSUE/WAIT, or beyond N_ARGS, belong to no live operation.
  assign ret_fire = isqrt_y_vld && (ret_q < CntW'(N_ARGS)) &&
                    ((state_q == StIssue) || (state_q == StWait));

  always_comb begin
    next_arg = '0;
    for (int unsigned i = 0; i < N_ARGS; i++) begin
      if (IdxW'(i) == idx_q + IdxW'(1)) next_arg = args_q[i*ARG_W +: ARG_W];
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    args_d  = args_q;
    idx_d   = idx_q;
    ret_d   = ret_q;
    acc_d   = acc_q;
    res_d   = res_q;
    x_vld_d = 1'b0;
    x_d     = x_q;
    if (ret_fire) begin
      acc_d = acc_q + RES_W'(isqrt_y);
      ret_d = ret_q + CntW'(1);
    end
    unique case (state_q)
      StDrain: begin
        if (drain_q != '0) drain_d = drain_q - DrnW'(1);
        if (drain_q <= DrnW'(1)) state_d = StIdle;
      end
      StIdle, StDone: begin
        state_d = StIdle;
        if (transfer) begin
          args_d  = args;
          acc_d   = '0;
          ret_d   = '0;
          idx_d   = '0;
          x_vld_d = 1'b1;
          x_d     = args[ARG_W-1:0];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (idx_q == IdxW'(N_ARGS - 1)) begin
          state_d = StWait;
        end else begin
          idx_d   = idx_q + IdxW'(1);
          x_vld_d = 1'b1;
          x_d     = next_arg;
        end
      end
      StWait: begin
        // Uses the post-update count so the last return and DONE entry share an edge.
        if (ret_d == CntW'(N_ARGS)) begin
          state_d = StDone;
          res_d   = acc_d;
        end
      end
      default: state_d = StDrain;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StDrain;
      drain_q <= DrnW'(ISQRT_LAT);
      args_q  <= '0;
      idx_q   <= '0;
      ret_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      x_vld_q <= 1'b0;
      x_q     <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      args_q  <= args_d;
      idx_q   <= idx_d;
      ret_q   <= ret_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      x_vld_q <= x_vld_d;
      x_q     <= x_d;
    end
  end

endmodule

// File: tb/tb_formula_n_pipe_aware_fsm.sv
// Directed bench: two sequencer configurations, each beside a bench isqrt pipeline model,
// with a scoreboard of expected results and accept cycles.
module tb_formula_n_pipe_aware_fsm;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;

  // Configuration A: N_ARGS=3, ISQRT_LAT=4
  logic        arg_vld, arg_rdy, res_vld, x_vld, y_vld;
  logic [95:0] args;
  logic [18:0] res;
  logic [31:0] x;
  logic [15:0] y;
  logic        inj_vld;
  logic [15:0] inj_y;
  logic [16:0] pipe_a [4] = '{default: '0};

  // Configuration B: N_ARGS=1, ISQRT_LAT=1
  logic        arg_vld2, arg_rdy2, res_vld2, x_vld2;
  logic [31:0] args2, x2;
  logic [16:0] res2;
  logic [16:0] pipe_b = '0;

  int          exp_q [$];
  int          acc_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] isqrt32(input logic [31:0] v);
    logic [63:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[15:0];
  endfunction

  always @(posedge clk) begin
    pipe_a[0] <= {x_vld, isqrt32(x)};
    for (int i = 1; i < 4; i++) pipe_a[i] <= pipe_a[i-1];
    pipe_b <= {x_vld2, isqrt32(x2)};
  end

  assign y_vld = pipe_a[3][16] | inj_vld;
  assign y     = inj_vld ? inj_y : pipe_a[3][15:0];

  formula_n_pipe_aware_fsm #(.N_ARGS(3), .ARG_W(32), .ISQRT_LAT(4)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .args(args),
    .res_vld(res_vld), .res(res), .isqrt_x_vld(x_vld), .isqrt_x(x),
    .isqrt_y_vld(y_vld), .isqrt_y(y)
  );

  formula_n_pipe_aware_fsm #(.N_ARGS(1), .ARG_W(32), .ISQRT_LAT(1)) dut2 (
    .clk(clk), .rst(rst), .arg_vld(arg_vld2), .arg_rdy(arg_rdy2), .args(args2),
    .res_vld(res_vld2), .res(res2), .isqrt_x_vld(x_vld2), .isqrt_x(x2),
    .isqrt_y_vld(pipe_b[16]), .isqrt_y(pipe_b[15:0])
  );

  // Scoreboard: each res_vld pops one expected result and its accept edge.
  always @(negedge clk) begin
    if (!rst && res_vld) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $error("FAIL unexpected_res_vld: observed 1 expected 0");
      end else begin
        int e, a;
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        n_checks++;
        if (res !== 19'(e)) begin
          n_fail++;
          $error("FAIL res_value: observed %0d expected %0d", res, e);
        end
        n_checks++;
        if ((cyc - a) !== 7) begin
          n_fail++;
          $error("FAIL res_latency: observed %0d expected 7", cyc - a);
        end
      end
    end
  end

  task automatic send(input logic [31:0] a0, a1, a2, input int e, input bit track,
                      output int acc_cyc);
    int t;
    @(negedge clk);
    args    = {a2, a1, a0};
    arg_vld = 1'b1;
    t = 0;
    while (!arg_rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (arg_rdy !== 1'b1) begin
      n_fail++;
      $error("FAIL accept_ready: observed %0d expected 1", arg_rdy);
    end
    acc_cyc = cyc + 1;
    if (track) begin
      exp_q.push_back(e);
      acc_q.push_back(acc_cyc);
    end
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $error("FAIL result_timeout: observed %0d expected 0", exp_q.size());
    end
  endtask

  // Called at the negedge where rst has just fallen.
  task automatic check_drain();
    n_checks++;
    if (arg_rdy !== 1'b0) begin
      n_fail++;
      $error("FAIL drain_rdy0: observed %0d expected 0", arg_rdy);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (arg_rdy !== 1'b0) begin
        n_fail++;
        $error("FAIL drain_rdy: observed %0d expected 0", arg_rdy);
      end
    end
    @(negedge clk);
    n_checks++;
    if (arg_rdy !== 1'b1) begin
      n_fail++;
      $error("FAIL drain_done_rdy: observed %0d expected 1", arg_rdy);
    end
  endtask

  initial begin
    int c1, c2;
    rst = 1'b1; arg_vld = 1'b0; args = '0; inj_vld = 1'b0; inj_y = '0;
    arg_vld2 = 1'b0; args2 = '0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (arg_rdy !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_arg_rdy: observed %0d expected 0", arg_rdy);
    end
    n_checks++;
    if (res_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_res_vld: observed %0d expected 0", res_vld);
    end
    n_checks++;
    if (x_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL rst_x_vld: observed %0d expected 0", x_vld);
    end
    n_checks++;
    if (res !== 19'd0) begin
      n_fail++;
      $error("FAIL rst_res: observed %0d expected 0", res);
    end
    n_checks++;
    if (x !== 32'd0) begin
      n_fail++;
      $error("FAIL rst_x: observed %0d expected 0", x);
    end
    rst = 1'b0;
    check_drain();

    // Basic op, with issue order checked
    send(32'd16, 32'd25, 32'd36, 15, 1'b1, c1);
    n_checks++;
    if (x_vld !== 1'b1) begin
      n_fail++;
      $error("FAIL issue0_vld: observed %0d expected 1", x_vld);
    end
    n_checks++;
    if (x !== 32'd16) begin
      n_fail++;
      $error("FAIL issue0_x: observed %0d expected 16", x);
    end
    @(negedge clk);
    n_checks++;
    if (x !== 32'd25) begin
      n_fail++;
      $error("FAIL issue1_x: observed %0d expected 25", x);
    end
    @(negedge clk);
    n_checks++;
    if (x !== 32'd36) begin
      n_fail++;
      $error("FAIL issue2_x: observed %0d expected 36", x);
    end
    @(negedge clk);
    n_checks++;
    if (x_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL issue_end_vld: observed %0d expected 0", x_vld);
    end
    wait_done();
    @(negedge clk);
    n_checks++;
    if (res_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL res_hold_vld: observed %0d expected 0", res_vld);
    end
    n_checks++;
    if (res !== 19'd15) begin
      n_fail++;
      $error("FAIL res_hold: observed %0d expected 15", res);
    end

    // Largest operands
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 196605, 1'b1, c1);
    wait_done();

    // Back-to-back, second offered while the first is finishing
    send(32'd0, 32'd1, 32'd4, 3, 1'b1, c1);
    send(32'd9, 32'd9, 32'd9, 9, 1'b1, c2);
    n_checks++;
    if ((c2 - c1) !== 8) begin
      n_fail++;
      $error("FAIL b2b_interval: observed %0d expected 8", c2 - c1);
    end
    wait_done();

    // Stray return while idle must not pollute the next result
    @(negedge clk);
    inj_vld = 1'b1; inj_y = 16'd7;
    @(negedge clk);
    inj_vld = 1'b0;
    send(32'd1, 32'd1, 32'd1, 3, 1'b1, c1);
    wait_done();

    // Reset in cycle 5 while returns are still in flight
    send(32'd100, 32'd100, 32'd100, 0, 1'b0, c1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (arg_rdy !== 1'b0) begin
      n_fail++;
      $error("FAIL midrst_rdy: observed %0d expected 0", arg_rdy);
    end
    n_checks++;
    if (x_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL midrst_x_vld: observed %0d expected 0", x_vld);
    end
    n_checks++;
    if (res_vld !== 1'b0) begin
      n_fail++;
      $error("FAIL midrst_res_vld: observed %0d expected 0", res_vld);
    end
    @(negedge clk);
    rst = 1'b0;
    check_drain();
    send(32'd4, 32'd4, 32'd4, 6, 1'b1, c1);
    wait_done();

    // Single-argument, latency-1 configuration
    begin
      int t, seen;
      @(negedge clk);
      args2 = 32'd49; arg_vld2 = 1'b1;
      n_checks++;
      if (arg_rdy2 !== 1'b1) begin
        n_fail++;
        $error("FAIL b_ready: observed %0d expected 1", arg_rdy2);
      end
      c1 = cyc + 1;
      @(posedge clk);
      @(negedge clk);
      arg_vld2 = 1'b0;
      t = 0; seen = 0;
      while (!res_vld2 && t < 20) begin
        @(negedge clk);
        t++;
      end
      seen = cyc;
      n_checks++;
      if (res_vld2 !== 1'b1) begin
        n_fail++;
        $error("FAIL b_res_vld: observed %0d expected 1", res_vld2);
      end
      n_checks++;
      if ((seen - c1) !== 2) begin
        n_fail++;
        $error("FAIL b_latency: observed %0d expected 2", seen - c1);
      end
      n_checks++;
      if (res2 !== 17'd7) begin
        n_fail++;
        $error("FAIL b_res: observed %0d expected 7", res2);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/formula_n_pipe_aware_fsm.md
Name: formula_n_pipe_aware_fsm

Overview:
- Parametrised FSM plus datapath that computes res = sum of isqrt(arg[i]) for i = 0..N_ARGS-1.
- Drives one external pipelined isqrt instance through its x/y ports; instantiates no isqrt itself.
- Sits beside that isqrt inside a top wrapper.
- Generalises the fixed 3-argument version:
  - argument count and widths are parametrised;
  - results are counted instead of trusting isqrt_y_vld to arrive contiguously;
  - adds a ready/valid input handshake, back-to-back acceptance and a post-reset pipeline drain.

Parameters:
- N_ARGS, 3, number of arguments per operation (>=1).
- ARG_W, 32, argument width; must be even.
- ISQRT_LAT, 4, isqrt latency: x_vld at cycle t gives y_vld at cycle t+ISQRT_LAT (>=1).
- RES_W, ARG_W/2+$clog2(N_ARGS)+1, result width; never overflows.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- arg_vld  in  1  argument vector valid.
- arg_rdy  out  1  block can accept; transfer occurs when arg_vld && arg_rdy at a rising edge.
- args  in  N_ARGS*ARG_W  packed arguments; arg[i] = args[i*ARG_W +: ARG_W].
- res_vld  out  1  one-cycle result strobe.
- res  out  RES_W  sum of square roots; valid only while res_vld is high.
- isqrt_x_vld  out  1  valid to isqrt.
- isqrt_x  out  ARG_W  operand to isqrt.
- isqrt_y_vld  in  1  isqrt result valid.
- isqrt_y  in  ARG_W/2  isqrt result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = DRAIN, drain counter = ISQRT_LAT;
  - arg_rdy, res_vld and isqrt_x_vld = 0;
  - res, isqrt_x and the accumulator = 0.
- DRAIN state:
  - arg_rdy = 0; isqrt_y_vld is ignored.
  - The counter decrements each cycle; at 0 the FSM goes to IDLE.
  - This flushes results still in flight from before reset.
- IDLE state:
  - arg_rdy = 1.
  - On a transfer: latch args into an internal register, clear the accumulator and the issue/return counters, go to ISSUE.
  - isqrt_y_vld seen in IDLE is ignored.
- ISSUE state (exactly N_ARGS cycles):
  - Registered outputs: isqrt_x_vld = 1 and isqrt_x = arg[issue_idx], with issue_idx running 0..N_ARGS-1.
  - After the last issue go to WAIT; isqrt_x_vld returns to 0.
- Accumulation (ISSUE and WAIT only):
  - Each cycle with isqrt_y_vld: acc <= acc + zero-extended isqrt_y, and ret_cnt increments.
- WAIT state:
  - When ret_cnt reaches N_ARGS, go to DONE.
  - The N_ARGS-th return may land during ISSUE if ISQRT_LAT is small; the counter handles this.
- DONE state (one cycle):
  - res_vld = 1 and res = acc.
  - arg_rdy = 1, so back-to-back acceptance is allowed.
  - Transfer in DONE goes to ISSUE with a fresh load; otherwise go to IDLE.
  - res holds its value after res_vld falls, until the next DONE.
- Timing, for an accept at edge 0:
  - isqrt_x_vld high in cycles 1..N_ARGS;
  - returns arrive in cycles 1+ISQRT_LAT..N_ARGS+ISQRT_LAT;
  - res_vld is high in cycle N_ARGS+ISQRT_LAT+1.
  - Minimum accept interval is N_ARGS+ISQRT_LAT+1 cycles.
- isqrt_x_vld pulses may be non-contiguous only if the design is later stalled; the current FSM always issues contiguously.
- Extra isqrt_y_vld beyond N_ARGS in the same operation is ignored.
- Missing returns leave the FSM in WAIT (no timeout).
- Reset mid-operation: outputs clear immediately, the in-flight op is discarded and no res_vld is produced for it; DRAIN then follows.
- args are sampled only at transfer; changes afterwards have no effect.

Test Plan:
- Setup: N_ARGS=3, ARG_W=32, ISQRT_LAT=4, bench isqrt model.
- After reset: arg_rdy stays 0 for 4 cycles, then goes to 1. Args {16,25,36} accepted at edge 0 -> isqrt_x = 16, 25, 36 in cycles 1-3; res_vld in cycle 8 with res = 15.
- Args all 0xFFFFFFFF -> res = 3*65535 = 196605; no overflow in RES_W = 19.
- Back-to-back: {0,1,4} then {9,9,9}, second offered during DONE -> res 3 then 9, accept interval exactly 8 cycles.
- Stray isqrt_y_vld=1 with isqrt_y=7 injected in IDLE, then op {1,1,1} -> res = 3.
- Assert rst in cycle 5 of op {100,100,100}, while model returns are still pending -> no res_vld, arg_rdy = 0 for 4 cycles. Then op {4,4,4} -> res = 6, unaffected by stale returns.
- Re-parametrise N_ARGS=1, ISQRT_LAT=1, op {49} -> res_vld in cycle 3, res = 7.
